// File: rtl/dbus_bridge_pkg.sv
// rtl/dbus_bridge_pkg.sv - state encodings and bus opcodes for the data-bus bridge
package dbus_bridge_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic BUS_OP_READ  = 1'b0;
  localparam logic BUS_OP_WRITE = 1'b1;

  // States in which the bridge is waiting on the bus and the timer runs.
  function automatic logic is_bus_state(input logic [2:0] st);
    return (st == ST_RD_REQ) || (st == ST_RD_WAIT) ||
           (st == ST_WR_REQ) || (st == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/dbus_bridge_bus_timer.sv
// rtl/dbus_bridge_bus_timer.sv - per-phase wait counter with TIMEOUT compare
module dbus_bridge_bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Holds at TIMEOUT so a stuck phase can never wrap past the compare.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - MEM-stage to data-bus bridge; stores are read-modify-write
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            stall,
  output logic            err,
  output logic            bus_valid,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ready,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            is_store_q, is_store_d;
  logic            err_q, err_d;
  logic            req;
  logic            timeout;

  assign req = mem_load | mem_store;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    is_store_d = is_store_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d     = address & ~XLEN'(3);
          is_store_d = mem_store;
          state_d    = ST_RD_REQ;
        end
      end
      ST_RD_REQ:  if (bus_ready) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          state_d = is_store_q ? ST_WR_REQ : ST_DONE;
        end
      end
      ST_WR_REQ:  if (bus_ready) state_d = ST_WR_WAIT;
      ST_WR_WAIT: if (bus_rvalid) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // A handshake landing in the expiry cycle still wins over the timeout.
    if (timeout && is_bus_state(state_q) && (state_d == state_q)) begin
      rdata_d = '0;
      err_d   = 1'b1;
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rdata_q    <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      is_store_q <= is_store_d;
      err_q      <= err_d;
    end
  end

  dbus_bridge_bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_bus_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (is_bus_state(state_q)),
    .expired (timeout)
  );

  assign stall     = (state_q == ST_IDLE) ? req : (state_q != ST_DONE);
  assign bus_valid = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign bus_we    = (state_q == ST_WR_REQ) ? BUS_OP_WRITE : BUS_OP_READ;
  assign bus_addr  = addr_q;
  // The core holds store_data steady while stalled, so it is forwarded unregistered.
  assign bus_wdata = (state_q == ST_WR_REQ) ? store_data : '0;
  assign load_data = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - directed self-checking bench for dbus_bridge
module tb_dbus_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_load, mem_store;
  logic [31:0] address, store_data, load_data;
  logic        stall, err, bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_acc, wr_acc, we_seen, err_cnt;
  logic [31:0] rd_addr, wr_addr, wr_data;

  always #5 clock = ~clock;

  dbus_bridge #(
    .XLEN    (32),
    .TIMEOUT (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .err        (err),
    .bus_valid  (bus_valid),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (bus_valid && bus_ready) begin
        if (bus_we) begin
          wr_acc++;
          wr_addr = bus_addr;
          wr_data = bus_wdata;
        end else begin
          rd_acc++;
          rd_addr = bus_addr;
        end
      end
      if (bus_we) we_seen++;
      if (err) err_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rd_acc  = 0;
    wr_acc  = 0;
    we_seen = 0;
    err_cnt = 0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic go_idle();
    @(posedge clock); #1;
    mem_load  = 1'b0;
    mem_store = 1'b0;
  endtask

  // Presents a request and returns at the negedge of the DONE cycle.
  task automatic run_access(input logic ld, input logic st, input logic [31:0] a,
                            input logic [31:0] sd, input string tag, output int stalls);
    bit done;
    done = 1'b0;
    @(posedge clock); #1;
    mem_load   = ld;
    mem_store  = st;
    address    = a;
    store_data = sd;
    clear_mon();
    stalls = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock);
      if (stall) stalls++;
      else done = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int st;
    int stable;
    bit done;

    reset = 1'b1; mem_load = 1'b0; mem_store = 1'b0; address = '0; store_data = '0;
    bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = '0;
    clear_mon();
    repeat (2) @(negedge clock);
    check_eq("rst_stall",     32'(stall),     32'd0);
    check_eq("rst_bus_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_bus_we",    32'(bus_we),    32'd0);
    check_eq("rst_err",       32'(err),       32'd0);
    check_eq("rst_load_data", load_data,      32'h0);
    mem_load = 1'b1; #1;
    check_eq("rst_stall_req", 32'(stall), 32'd1);
    mem_load = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // zero-wait load
    bus_rdata = 32'hDEADBEEF;
    run_access(1'b1, 1'b0, 32'h100, 32'h0, "ld", st);
    check_eq("ld_stalls", 32'(st),      32'd3);
    check_eq("ld_data",   load_data,    32'hDEADBEEF);
    check_eq("ld_rd_acc", 32'(rd_acc),  32'd1);
    check_eq("ld_raddr",  rd_addr,      32'h100);
    check_eq("ld_we",     32'(we_seen), 32'd0);
    check_eq("ld_err",    32'(err),     32'd0);
    go_idle();

    // zero-wait unaligned store
    bus_rdata = 32'hAABBCCDD;
    run_access(1'b0, 1'b1, 32'h103, 32'h11223344, "st", st);
    check_eq("st_stalls", 32'(st),     32'd5);
    check_eq("st_rd_acc", 32'(rd_acc), 32'd1);
    check_eq("st_wr_acc", 32'(wr_acc), 32'd1);
    check_eq("st_raddr",  rd_addr,     32'h100);
    check_eq("st_waddr",  wr_addr,     32'h100);
    check_eq("st_wdata",  wr_data,     32'h11223344);
    check_eq("st_rdata",  load_data,   32'hAABBCCDD);
    go_idle();

    // load and store together behave as a store
    bus_rdata = 32'h55667788;
    run_access(1'b1, 1'b1, 32'h20A, 32'hCAFEF00D, "both", st);
    check_eq("both_stalls", 32'(st),     32'd5);
    check_eq("both_wr_acc", 32'(wr_acc), 32'd1);
    check_eq("both_waddr",  wr_addr,     32'h208);
    check_eq("both_wdata",  wr_data,     32'hCAFEF00D);
    go_idle();

    // bus_ready held low for four RD_REQ cycles
    bus_rdata = 32'h0BADF00D;
    @(posedge clock); #1;
    clear_mon();
    bus_ready = 1'b0; mem_load = 1'b1; address = 32'h204;
    @(negedge clock);
    check_eq("rdy_idle_stall", 32'(stall), 32'd1);
    stable = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus_valid === 1'b1 && bus_we === 1'b0 && bus_addr === 32'h204) stable++;
    end
    check_eq("rdy_stable", 32'(stable), 32'd4);
    check_eq("rdy_no_acc", 32'(rd_acc), 32'd0);
    @(posedge clock); #1;
    bus_ready = 1'b1;
    @(negedge clock); #1;
    check_eq("rdy_acc5", 32'(rd_acc), 32'd1);
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clock);
      if (!stall) done = 1'b1;
    end
    check_eq("rdy_done", 32'(done), 32'd1);
    check_eq("rdy_data", load_data, 32'h0BADF00D);
    go_idle();

    // read response never arrives: timeout aborts the store
    bus_rvalid = 1'b0;
    run_access(1'b0, 1'b1, 32'h300, 32'h12345678, "to", st);
    check_eq("to_stalls", 32'(st),     32'd11);
    check_eq("to_err",    32'(err),    32'd1);
    check_eq("to_data",   load_data,   32'h0);
    check_eq("to_rd_acc", 32'(rd_acc), 32'd1);
    check_eq("to_wr_acc", 32'(wr_acc), 32'd0);
    go_idle();
    @(negedge clock);
    check_eq("to_err_cnt", 32'(err_cnt), 32'd1);
    bus_rvalid = 1'b1;

    // reset while the write acknowledge is pending
    bus_rdata = 32'h77778888;
    @(posedge clock); #1;
    clear_mon();
    mem_store = 1'b1; address = 32'h400; store_data = 32'h9999AAAA;
    repeat (3) @(negedge clock);
    @(posedge clock); #1;
    bus_rvalid = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check_eq("wrw_stall",  32'(stall),     32'd1);
    check_eq("wrw_valid",  32'(bus_valid), 32'd0);
    check_eq("wrw_wr_acc", 32'(wr_acc),    32'd1);
    check_eq("wrw_data",   load_data,      32'h77778888);
    reset = 1'b1; mem_store = 1'b0;
    #1;
    check_eq("wrw_rst_stall", 32'(stall),     32'd0);
    check_eq("wrw_rst_valid", 32'(bus_valid), 32'd0);
    check_eq("wrw_rst_data",  load_data,      32'h0);
    @(posedge clock); #1;
    reset = 1'b0; bus_rvalid = 1'b1;
    bus_rdata = 32'h13579BDF;
    run_access(1'b1, 1'b0, 32'h440, 32'h0, "post", st);
    check_eq("post_stalls", 32'(st),     32'd3);
    check_eq("post_data",   load_data,   32'h13579BDF);
    check_eq("post_wr_acc", 32'(wr_acc), 32'd0);
    check_eq("post_raddr",  rd_addr,     32'h440);
    go_idle();

    // back-to-back load then store
    bus_rdata = 32'h2468ACE0;
    run_access(1'b1, 1'b0, 32'h500, 32'h0, "b2b_ld", st);
    check_eq("b2b_ld_stalls", 32'(st),     32'd3);
    check_eq("b2b_ld_data",   load_data,   32'h2468ACE0);
    check_eq("b2b_ld_rd_acc", 32'(rd_acc), 32'd1);
    bus_rdata = 32'h0F0F0F0F;
    run_access(1'b0, 1'b1, 32'h504, 32'h31415926, "b2b_st", st);
    check_eq("b2b_st_stalls", 32'(st),     32'd5);
    check_eq("b2b_st_rd_acc", 32'(rd_acc), 32'd1);
    check_eq("b2b_st_wr_acc", 32'(wr_acc), 32'd1);
    check_eq("b2b_st_waddr",  wr_addr,     32'h504);
    check_eq("b2b_st_wdata",  wr_data,     32'h31415926);
    go_idle();
    repeat (2) @(negedge clock);
    check_eq("end_stall", 32'(stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
